button_event_fsm: RTL and testbench

Consumer-side companion to the button debouncer on the Poncho board. It takes a clean, debounced button level and turns it into single-cycle user events: press, release, long-press and auto-repeat. The hex counter and other front-panel logic use these events to step values once per tap, or continuously while a button is held.

---
 rtl/button_event_fsm.sv | 151 +++++++++++++++
 tb/tb_button_event_fsm.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_event_fsm.sv
// button_event_fsm
// Turns a debounced button level into single-cycle press / release /
// long-press / auto-repeat events plus a "held" level. Edge detection
// runs every cycle; event generation is gated by enable.

module button_event_fsm #(
  parameter int unsigned CLK_FREQ_HZ   = 12000000,
  parameter int unsigned LONG_PRESS_MS = 500,
  parameter int unsigned REPEAT_MS     = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic held
);

  // Cycle counts computed in 64 bits: the default clock times the
  // millisecond values overflows 32-bit arithmetic.
  localparam longint unsigned LC   = (64'(CLK_FREQ_HZ) * 64'(LONG_PRESS_MS)) / 64'd1000;
  localparam longint unsigned RC   = (64'(CLK_FREQ_HZ) * 64'(REPEAT_MS)) / 64'd1000;
  localparam longint unsigned MAXC = (LC > RC) ? LC : RC;
  localparam int              CW   = (MAXC > 64'd1) ? $clog2(MAXC) : 1;

  // Terminal counts: the counter starts at 0 on entry, so the event fires
  // when it reaches N-1, i.e. exactly N cycles after the state was entered.
  localparam logic [CW-1:0] L_TC = CW'(LC - 64'd1);
  localparam logic [CW-1:0] R_TC = CW'(RC - 64'd1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          btn_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic press_q,   press_d;
  logic release_q, release_d;
  logic long_q,    long_d;
  logic repeat_q,  repeat_d;
  logic step_q,    step_d;

  logic rise, fall;
  logic l_done, r_done;

  // Edge detect against the previous sample; independent of enable so a
  // button already down when enable rises does not look like a new press.
  assign rise   = btn_in & ~btn_q;
  assign fall   = ~btn_in & btn_q;
  assign l_done = (cnt_q == L_TC);
  assign r_done = (cnt_q == R_TC);

  // State, counter, edge-detect history and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      btn_q     <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_in;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
    end
  end

  // Next state and counter. Priority: enable low, then release, then
  // terminal count. The counter is cleared on every transition and at
  // every terminal count, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (fall) begin
            state_d = S_IDLE;
          end else if (l_done) begin
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (fall) begin
            state_d = S_IDLE;
          end else if (!r_done) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulse values for the next cycle; all default low, and enable low
  // suppresses everything including the release event.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          press_d = rise;
        end
        S_HOLD: begin
          release_d = fall;
          long_d    = ~fall & l_done;
        end
        S_REPEAT: begin
          release_d = fall;
          repeat_d  = ~fall & r_done;
        end
        default: ;
      endcase
    end
    step_d = press_d | repeat_d;
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = step_q;
  assign held          = (state_q == S_HOLD) || (state_q == S_REPEAT);

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed table-driven bench for button_event_fsm with L=10, R=4.
// Each table row is one clock: inputs applied before the edge, outputs
// {press,release,long,repeat,step,held} compared just after it.

module tb_button_event_fsm;

  logic clk = 1'b0;
  logic rst, btn_in, enable;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse, held;

  button_event_fsm #(
    .CLK_FREQ_HZ  (1000),
    .LONG_PRESS_MS(10),
    .REPEAT_MS    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .enable       (enable),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .step_pulse   (step_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Expected-output codes {press,release,long,repeat,step,held}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_PRS  = 6'b100011;
  localparam logic [5:0] O_HELD = 6'b000001;
  localparam logic [5:0] O_REL  = 6'b010000;
  localparam logic [5:0] O_LONG = 6'b001001;
  localparam logic [5:0] O_REP  = 6'b000111;

  localparam int SEG_TAP = 1, SEG_GLITCH = 2, SEG_TC = 3, SEG_LONG = 4, SEG_EN = 5;

  typedef struct {
    logic       btn;
    logic       en;
    logic [5:0] exp;
    int         seg;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;
  int long_steps = 0;

  function automatic void add(input logic b, input logic e, input logic [5:0] x, input int s);
    vec_t v;
    v.btn = b; v.en = e; v.exp = x; v.seg = s;
    vecs.push_back(v);
  endfunction

  function automatic logic [5:0] obs();
    return {press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse, held};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic b, input logic e);
    @(negedge clk);
    btn_in = b;
    enable = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; btn_in = 1'b0; enable = 1'b1;
    #2;
    check("reset_async", obs(), O_NONE);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", obs(), O_NONE);
    @(negedge clk);
    rst = 1'b0;

    // Idle lead-in
    add(0, 1, O_NONE, 0);
    add(0, 1, O_NONE, 0);

    // Short tap: 5 cycles high
    add(1, 1, O_PRS, SEG_TAP);
    for (int k = 1; k < 5; k++) add(1, 1, O_HELD, SEG_TAP);
    add(0, 1, O_REL, SEG_TAP);
    add(0, 1, O_NONE, SEG_TAP);

    // One-cycle glitch
    add(1, 1, O_PRS, SEG_GLITCH);
    add(0, 1, O_REL, SEG_GLITCH);
    add(0, 1, O_NONE, SEG_GLITCH);

    // Release exactly at the long-press terminal count
    add(1, 1, O_PRS, SEG_TC);
    for (int k = 1; k < 10; k++) add(1, 1, O_HELD, SEG_TC);
    add(0, 1, O_REL, SEG_TC);
    add(0, 1, O_NONE, SEG_TC);

    // Long hold: 25 cycles high
    add(1, 1, O_PRS, SEG_LONG);
    for (int k = 1; k < 25; k++) begin
      if (k == 10)                       add(1, 1, O_LONG, SEG_LONG);
      else if (k == 14 || k == 18 || k == 22) add(1, 1, O_REP, SEG_LONG);
      else                               add(1, 1, O_HELD, SEG_LONG);
    end
    add(0, 1, O_REL, SEG_LONG);
    add(0, 1, O_NONE, SEG_LONG);

    // Enable gating mid-hold, then re-enable while still held
    add(1, 1, O_PRS, SEG_EN);
    for (int k = 1; k < 7; k++) add(1, 1, O_HELD, SEG_EN);
    add(1, 0, O_NONE, SEG_EN);
    for (int k = 0; k < 5; k++) add(1, 0, O_NONE, SEG_EN);
    for (int k = 0; k < 12; k++) add(1, 1, O_NONE, SEG_EN);
    add(0, 1, O_NONE, SEG_EN);
    add(1, 1, O_PRS, SEG_EN);
    add(0, 1, O_REL, SEG_EN);
    add(0, 1, O_NONE, SEG_EN);

    foreach (vecs[i]) begin
      logic [5:0] got;
      cyc(vecs[i].btn, vecs[i].en);
      got = obs();
      check($sformatf("row%0d_seg%0d", i, vecs[i].seg), got, vecs[i].exp);
      if (vecs[i].seg == SEG_LONG && step_pulse) long_steps++;
    end
    check_int("long_step_count", long_steps, 4);

    // Reset asserted mid-repeat, then released with the button down
    for (int k = 0; k < 16; k++) cyc(1, 1);
    check("pre_reset_repeat", obs(), O_HELD);
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_repeat", obs(), O_NONE);
    @(posedge clk);
    #1;
    check("reset_no_release", obs(), O_NONE);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("press_after_reset", obs(), O_PRS);
    cyc(1, 1);
    check("held_after_reset", obs(), O_HELD);
    cyc(0, 1);
    check("release_after_reset", obs(), O_REL);
    cyc(0, 1);
    check("idle_after_reset", obs(), O_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
